// File: rtl/ct_spsram_512x54_ctrl.sv
// Access controller for the 512x54 single-port SRAM macro: array clear, one LSU access per cycle, read-data alignment.
// Latency: read data valid one cycle after acceptance; backpressure: req_rdy low outside RUN and whenever init_req is high.
module ct_spsram_512x54_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 54,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  init_req,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwe,
  output logic                  req_rdy,
  output logic                  init_done,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_init_done;
  logic                    r_rd_vld;
  logic [DATA_WIDTH-1:0]   r_hold;

  logic                    w_run;
  logic                    w_acc;

  assign w_run = (r_state == ST_RUN);
  // init_req has priority over a same-cycle request; the master must hold it.
  assign w_acc = w_run & req_vld & ~init_req;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state     <= ST_RST;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_rd_vld <= w_acc & ~req_wr;
      if (r_rd_vld) begin
        r_hold <= sram_q;
      end
      case (r_state)
        ST_RST: begin
          r_state     <= ST_INIT;
          r_cnt       <= '0;
          r_init_done <= 1'b0;
        end
        ST_INIT: begin
          if (init_req) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
              r_state     <= ST_RUN;
              r_init_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (init_req) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RST;
          r_cnt       <= '0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (r_state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = r_cnt;
      sram_d    = INIT_VAL;
    end else if (w_acc) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_bwe;
        sram_d    = req_wdata;
      end
    end
  end

  assign req_rdy   = w_run & ~init_req;
  assign init_done = r_init_done;
  assign rd_vld    = r_rd_vld;
  assign rd_data   = r_rd_vld ? sram_q : r_hold;

endmodule

// File: doc/ct_spsram_512x54_ctrl.md
# ct_spsram_512x54_ctrl

Access controller placed directly upstream of the 512x54 single-port SRAM macro wrapper. It clears the array after reset or on request, accepts one read or write per cycle from the LSU over a valid/ready port, and drives the macro's active-low pins (CEN, GWEN, bitwise WEN). It also aligns the macro's next-cycle read data with a valid strobe and holds it until the next read.

## Interface

Parameters:
- ADDR_WIDTH, 9, SRAM address width (512 entries)
- DATA_WIDTH, 54, data and bit-write-enable width
- INIT_VAL, 54'b0, word written to every entry during initialization

Ports:
- forever_cpuclk  in  1  single clock; all state on the rising edge
- cpurst  in  1  reset, asynchronous, active-high
- init_req  in  1  pulse; (re)start full-array initialization
- req_vld  in  1  access request valid
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  9  entry address
- req_wdata  in  54  write data
- req_bwe  in  54  per-bit write enable, active-high; ignored for reads
- req_rdy  out  1  request accepted this cycle when req_vld & req_rdy
- init_done  out  1  array initialized; high in RUN
- rd_vld  out  1  read data valid, one cycle after a read is accepted
- rd_data  out  54  read data
- sram_a  out  9  to macro A
- sram_cen  out  1  to macro CEN, active-low chip enable
- sram_gwen  out  1  to macro GWEN, active-low global write enable
- sram_wen  out  54  to macro WEN, active-low bit write enable
- sram_d  out  54  to macro D
- sram_q  in  54  from macro Q

## Operation

- States: RST, INIT, RUN. Reset forces RST; the first clock after reset release moves to INIT with counter = 0.
- INIT: each cycle drives cen=0, gwen=0, wen=all 0, a=counter, d=INIT_VAL, then increments the counter. At counter = 511 the state moves to RUN. The counter is 9 bits and wraps to 0 unused.
- RUN:
  - req_rdy = ~init_req.
  - On an accepted request: cen=0, a=req_addr.
  - Write: gwen=0, wen=~req_bwe, d=req_wdata.
  - Read: gwen=1, wen=all 1, d=0.
- Idle cycles (RUN with no accepted request, RST, or a cycle where init_req wins): cen=1, gwen=1, wen=all 1, a=0, d=0. The SRAM outputs are combinational from the state, counter and request.
- Write with req_bwe = 0 is still issued (cen=0, gwen=0, wen=all 1). The array content is unchanged.
- init_req:
  - In RUN: that cycle's request is not accepted; go to INIT with counter = 0 next cycle.
  - In INIT: counter restarts at 0.
  - In RST: ignored.
- Read return: rd_vld is a flop set by an accepted read, otherwise cleared.
  - When rd_vld=1, rd_data = sram_q and the value is captured into a 54-bit hold register at that edge.
  - When rd_vld=0, rd_data = hold register.
- A read accepted in the last RUN cycle before init_req still returns rd_vld normally.
- init_done = (state == RUN).
- req_rdy, init_done and all sram_* outputs are 0/idle outside RUN/INIT as specified. There is no clock gating.

## Timing

- Reset values:
  - state RST, counter 0
  - init_done=0, req_rdy=0, rd_vld=0, rd_data=0 (hold=0)
  - sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0
- After reset release at edge E0:
  - INIT occupies cycles E1..E512 (512 writes).
  - init_done=1 and req_rdy=1 from cycle E513.
- Request latency:
  - Accepted at edge k: the macro samples the pins at edge k.
  - For a read, rd_vld=1 during cycle k+1 with rd_data = sram_q.
  - Back-to-back reads are supported at one per cycle.
- Write followed by read of the same address on the next cycle returns the new data.
- Reset asserted mid-INIT or mid-read: all outputs return to reset values immediately (asynchronous). A pending rd_vld is dropped. Initialization restarts in full after release.
- Simultaneous init_req and req_vld in RUN: init wins, req_rdy=0, and the master must hold its request.

## Test plan

- Reset release -> exactly 512 cycles of cen=0/gwen=0/wen=0 with a = 0..511 in order and d=INIT_VAL; init_done rises on the 513th cycle; req_rdy=0 throughout INIT.
- Write addr 0x1A5, wdata 0x2A_5A5A_5A5A_5A5A, bwe all 1; read 0x1A5 next cycle -> gwen=0 then gwen=1; rd_vld one cycle after the read with rd_data = written value; rd_data holds that value for 10 idle cycles.
- Partial write to addr 3 with bwe = 0x00_0000_0000_FFFF and data all 1 after init -> wen = ~bwe; read returns 0x00_0000_0000_FFFF.
- 8 back-to-back reads of addresses 0..7 -> rd_vld high 8 consecutive cycles, each returning the data of its own address, in order.
- init_req asserted with req_vld in RUN -> req_rdy=0 that cycle; 512 init cycles follow; every previously written entry then reads INIT_VAL.
- cpurst asserted at INIT counter 200 -> sram_cen=1 immediately; after release, init restarts at address 0 and init_done asserts 513 cycles after release.
